// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREGS x XLEN register file with two combinational read
// ports, two write ports (port 3 wins on address collision) and a per-register
// pending bit that marks registers with an in-flight writer.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   a1,
   input  logic [AW-1:0]   a2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy1,
   output logic            busy2,
   input  logic [AW-1:0]   a3,
   input  logic            we3,
   input  logic [XLEN-1:0] wd3,
   input  logic [AW-1:0]   a4,
   input  logic            we4,
   input  logic [XLEN-1:0] wd4,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] pending;

   logic acc3, acc4, acc_issue;

   // Accepted events: writes and issues to r0 are dropped
   always_comb begin
      acc3      = we3 && (a3 != '0);
      acc4      = we4 && (a4 != '0);
      acc_issue = issue_valid && (issue_rd != '0);
   end

   // Storage update: reset clears everything; port 3 is applied last so it wins a collision
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[AW'(i)] <= '0;
         end
      end else begin
         if (acc4) regs[a4] <= wd4;
         if (acc3) regs[a3] <= wd3;
      end
   end

   // Pending vector: writes clear, issue is applied last so set wins over clear
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         if (acc4)      pending[a4]       <= 1'b0;
         if (acc3)      pending[a3]       <= 1'b0;
         if (acc_issue) pending[issue_rd] <= 1'b1;
      end
   end

   // Read ports: r0 reads zero; optional forwarding from the write ports
   always_comb begin
      rd1   = (a1 == '0) ? '0 : regs[a1];
      rd2   = (a2 == '0) ? '0 : regs[a2];
      busy1 = pending[a1];
      busy2 = pending[a2];
`ifdef REGFILE_BYPASS_EN
      // Port 4 checked first so a port-3 match overrides it, mirroring the storage priority
      if (!rst && acc4 && (a4 == a1)) begin
         rd1   = wd4;
         busy1 = 1'b0;
      end
      if (!rst && acc3 && (a3 == a1)) begin
         rd1   = wd3;
         busy1 = 1'b0;
      end
      if (!rst && acc4 && (a4 == a2)) begin
         rd2   = wd4;
         busy2 = 1'b0;
      end
      if (!rst && acc3 && (a3 == a2)) begin
         rd2   = wd3;
         busy2 = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a
// randomized phase; expectations are queued and compared once per cycle.
module tb_regfile_scoreboard;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   a1, a2, a3, a4, issue_rd;
   logic [XLEN-1:0] rd1, rd2, wd3, wd4;
   logic            busy1, busy2, we3, we4, issue_valid;

   regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk(clk), .rst(rst),
      .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
      .a3(a3), .we3(we3), .wd3(wd3),
      .a4(a4), .we4(we4), .wd4(wd4),
      .issue_valid(issue_valid), .issue_rd(issue_rd)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [1:0]  kind;   // 0 rd1, 1 rd2, 2 busy1, 3 busy2
      logic [31:0] val;
   } exp_t;

   exp_t  sbq  [$];
   string tagq [$];

   // Reference model state
   logic [XLEN-1:0]  m_regs [NREGS];
   logic [NREGS-1:0] m_pend;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [1:0] kind, input logic [31:0] val);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      sbq.push_back(e);
      tagq.push_back(tag);
   endtask

   function automatic logic fwd3(input logic [AW-1:0] a);
      return BYP && !rst && we3 && (a3 == a) && (a != '0);
   endfunction

   function automatic logic fwd4(input logic [AW-1:0] a);
      return BYP && !rst && we4 && (a4 == a) && (a != '0);
   endfunction

   function automatic logic [XLEN-1:0] m_rd(input logic [AW-1:0] a);
      if (a == '0) return '0;
      if (fwd3(a)) return wd3;
      if (fwd4(a)) return wd4;
      return m_regs[a];
   endfunction

   function automatic logic m_busy(input logic [AW-1:0] a);
      if (a == '0) return 1'b0;
      if (fwd3(a) || fwd4(a)) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic m_step();
      if (rst) begin
         for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
         m_pend = '0;
      end else begin
         if (we4 && a4 != '0) begin m_regs[a4] = wd4; m_pend[a4] = 1'b0; end
         if (we3 && a3 != '0) begin m_regs[a3] = wd3; m_pend[a3] = 1'b0; end
         if (issue_valid && issue_rd != '0) m_pend[issue_rd] = 1'b1;
      end
   endtask

   // One clock: queue model expectations, compare everything at negedge, advance model and clock
   task automatic cycle();
      exp_t  e;
      string t;
      logic [31:0] act;
      push("m_rd1", 2'd0, m_rd(a1));
      push("m_rd2", 2'd1, m_rd(a2));
      push("m_busy1", 2'd2, 32'(m_busy(a1)));
      push("m_busy2", 2'd3, 32'(m_busy(a2)));
      @(negedge clk);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         t = tagq.pop_front();
         case (e.kind)
            2'd0:    act = rd1;
            2'd1:    act = rd2;
            2'd2:    act = 32'(busy1);
            default: act = 32'(busy2);
         endcase
         chk(t, act, e.val);
      end
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; we3 = 1'b0; we4 = 1'b0; issue_valid = 1'b0;
      a3 = '0; a4 = '0; wd3 = '0; wd4 = '0; issue_rd = '0;
   endtask

   initial begin
      idle();
      rst = 1'b1; a1 = '0; a2 = '0;
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_pend = '0;
      @(posedge clk);
      #1;

      // Reset state
      idle(); a1 = 5'd9; a2 = 5'd31;
      push("rst_rd1", 0, 0); push("rst_rd2", 1, 0); push("rst_busy1", 2, 0); push("rst_busy2", 3, 0);
      cycle();

      // Write to r0 is discarded
      we3 = 1'b1; a3 = 5'd0; wd3 = 200; a1 = 5'd0;
      cycle();
      idle();
      push("r0_rd1", 0, 0); push("r0_busy1", 2, 0);
      cycle();

      // Write latency / bypass
      we3 = 1'b1; a3 = 5'd1; wd3 = 200; a1 = 5'd1;
      push("wr1_same", 0, BYP ? 200 : 0);
      cycle();
      idle();
      push("wr1_next", 0, 200);
      cycle();

      // Dual-port collision: port 3 wins, in storage and on the bypass path
      we3 = 1'b1; a3 = 5'd5; wd3 = 100; we4 = 1'b1; a4 = 5'd5; wd4 = 150; a2 = 5'd5;
      push("coll_same", 1, BYP ? 100 : 0);
      cycle();
      idle();
      push("coll_next", 1, 100);
      cycle();

      // Issue then write-back clears pending
      issue_valid = 1'b1; issue_rd = 5'd7;
      cycle();
      idle(); a1 = 5'd7;
      push("iss_busy", 2, 1);
      cycle();
      we4 = 1'b1; a4 = 5'd7; wd4 = 42;
      push("wb_busy_same", 2, BYP ? 0 : 1);
      push("wb_rd_same", 0, BYP ? 42 : 0);
      cycle();
      idle();
      push("wb_busy_next", 2, 0); push("wb_rd_next", 0, 42);
      cycle();

      // Simultaneous issue and write: set wins
      issue_valid = 1'b1; issue_rd = 5'd3; we3 = 1'b1; a3 = 5'd3; wd3 = 9;
      cycle();
      idle(); a1 = 5'd3;
      push("setwin_busy", 2, 1); push("setwin_rd", 0, 9);
      cycle();

      // Reset overrides simultaneous write and issue
      we3 = 1'b1; a3 = 5'd2; wd3 = 77; issue_valid = 1'b1; issue_rd = 5'd4;
      cycle();
      idle(); a1 = 5'd2; a2 = 5'd4;
      push("pre_rd1", 0, 77); push("pre_busy2", 3, 1);
      cycle();
      rst = 1'b1; we3 = 1'b1; a3 = 5'd2; wd3 = 55; issue_valid = 1'b1; issue_rd = 5'd6;
      cycle();
      idle(); a1 = 5'd2; a2 = 5'd6;
      push("post_rd1", 0, 0); push("post_rd2", 1, 0); push("post_busy1", 2, 0); push("post_busy2", 3, 0);
      cycle();
      a1 = 5'd4; a2 = 5'd7;
      push("post_busy4", 2, 0); push("post_rd7", 1, 0);
      cycle();

      // Randomized traffic on a narrow address set to provoke collisions
      for (int n = 0; n < 400; n++) begin
         rst         = ($urandom_range(0, 49) == 0);
         we3         = $urandom_range(0, 1);
         we4         = $urandom_range(0, 1);
         issue_valid = $urandom_range(0, 1);
         a3          = AW'($urandom_range(0, 7));
         a4          = AW'($urandom_range(0, 7));
         issue_rd    = AW'($urandom_range(0, 7));
         a1          = AW'($urandom_range(0, 7));
         a2          = AW'($urandom_range(0, 7));
         wd3         = $urandom;
         wd4         = $urandom;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
